deck_shuffler: RTL
==================

# deck_shuffler

Card-source stage directly upstream of the blackjack controller. Loads an ordered 52-card deck, shuffles it in place with an LFSR-driven Fisher–Yates pass, then serves one card per draw request. It owns the "shuffle and load" period that follows reset; the controller's deal/hit logic issues `draw` and consumes the card fields.

## Interface

**Parameters**
- `SEED`, default `6'b011110`: LFSR load value on reset. Must be nonzero.

**Ports**
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `shuffle`, in, 1: reshuffle request. Honoured only in READY or EMPTY.
- `draw`, in, 1: card request. Honoured only in READY.
- `ready`, out, 1: deck shuffled and at least one card remains.
- `empty`, out, 1: all 52 cards dealt.
- `card_valid`, out, 1: one-cycle pulse; card fields are valid.
- `card_rank`, out, 4: 1..13 (A, 2..10, J, Q, K).
- `card_suit`, out, 2: 0..3.
- `card_points`, out, 4: blackjack value. Ace = 1 (controller promotes to 11). J/Q/K = 10.
- `cards_left`, out, 6: undealt cards, 0..52.

## Operation

- **Deck storage**: 52 × 6-bit register array `deck[i]` holds card index 0..51. Index encoding: `idx = suit*13 + (rank-1)`.
- **LFSR**: 6-bit Fibonacci, x^6+x^5+1, period 63.
  - Loaded with `SEED` on `rst` only. It keeps running across reshuffles, so successive decks differ.
  - Candidate `j = lfsr - 1`, range 0..62.
- **States**:
  - **INIT**: write `deck[k] = k` for k = 0..51, one entry per cycle. Then set `i = 51` and go to PICK.
  - **PICK**: step the LFSR each cycle. If `j <= i`, latch `j` and go to SWAP. Otherwise stay in PICK. Exit within 63 cycles is guaranteed.
  - **SWAP**: exchange `deck[i]` and `deck[j]` in one cycle (`j == i` is a no-op swap).
    - If `i == 1`: set `ptr = 0` and go to READY.
    - Otherwise: decrement `i` and go to PICK.
  - **READY**: on `draw`, output the decode of `deck[ptr]` and increment `ptr`. When `ptr` reaches 52, go to EMPTY.
  - **EMPTY**: `draw` is ignored.
- **Shuffle request**: `shuffle` in READY or EMPTY goes to INIT. The rest of the deck is discarded and `ptr` is cleared. `shuffle` is ignored in INIT, PICK and SWAP.
- **Simultaneous `draw` and `shuffle` in READY**: shuffle wins. No `card_valid`, `ptr` unchanged before the reload.
- **Outputs**:
  - `cards_left = 52 - ptr`. It reads 52 during the shuffle.
  - `ready` is high only in READY; `empty` is high only in EMPTY.
- **Reset mid-operation** (any state): return to INIT, reload the LFSR with `SEED`, restart the full load and shuffle.

## Timing

- **Reset values**: state = INIT, `ready` 0, `empty` 0, `card_valid` 0, `card_rank` 0, `card_suit` 0, `card_points` 0, `cards_left` 52, `ptr` 0, `lfsr` = `SEED`.
- **INIT**: 52 cycles. INIT begins on the first cycle after `rst` is deasserted.
- **Shuffle latency**: 52 + Σ(PICK cycles + 1) over i = 51..1. Worst case 52 + 51×64 = 3316 cycles. The result is deterministic for a given `SEED`.
- **Draw**: `draw` sampled high in READY at edge N. At edge N+1 the card fields are registered, `card_valid` = 1, and `cards_left` is decremented. `card_valid` returns to 0 at N+2 unless `draw` is held.
  - Back-to-back draws are legal: one card per cycle.
  - Card fields hold their value between pulses.
- **52nd draw**: at N+1 `card_valid` = 1, `empty` = 1, `ready` = 0, all in the same cycle.

## Structure

- **Shared package `blackjack_pkg`**:
  - State enum (INIT, PICK, SWAP, READY, EMPTY).
  - `DECK_SIZE = 52`, `RANKS = 13`.
  - LFSR tap mask and default seed.
  - Card field widths (`RANK_W = 4`, `SUIT_W = 2`, `PTS_W = 4`). The controller imports the same constants.
- **Sub-module `card_decode`**: combinational idx → rank/suit/points. The controller's display path reuses it.

## Test plan

- **Reset and load**: reset held 2 cycles, then released. `ready` rises within 3316 cycles with `cards_left` = 52. Across the whole interval `empty` = 0 and `card_valid` = 0.
- **Full deal**: 52 consecutive draws give 52 `card_valid` pulses with all (suit, rank) pairs distinct. `cards_left` steps 51..0. After the last pulse `empty` = 1. A 53rd draw gives no pulse.
- **Decode**: forced deck entries check idx 0 → rank 1, suit 0, pts 1; idx 12 → rank 13, pts 10; idx 22 → suit 1, rank 10, pts 10; idx 51 → suit 3, rank 13.
- **Determinism**: two resets with `SEED = 6'b011110` give identical 52-card sequences. A reshuffle without reset gives a different sequence. The LFSR never reads 0.
- **Conflicts**: `draw` and `shuffle` asserted in the same cycle in READY → no `card_valid`, state goes to INIT, `cards_left` = 52. `shuffle` during PICK → ignored.
- **Mid-operation reset**: `rst` asserted during PICK at i = 30, and separately after 10 draws. Both recover to a fresh INIT with the LFSR reloaded, and reproduce the reset sequence.

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared constants, state encoding and LFSR helper for the blackjack card path.
package blackjack_pkg;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_PICK  = 3'd1,
      ST_SWAP  = 3'd2,
      ST_READY = 3'd3,
      ST_EMPTY = 3'd4
   } deck_state_e;

   localparam int DECK_SIZE = 52;
   localparam int RANKS     = 13;
   localparam int IDX_W     = 6;
   localparam int LFSR_W    = 6;
   localparam int RANK_W    = 4;
   localparam int SUIT_W    = 2;
   localparam int PTS_W     = 4;

   // x^6 + x^5 + 1: feedback is the XOR of the two top bits.
   localparam logic [LFSR_W-1:0] LFSR_TAPS    = 6'b110000;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 6'b011110;

   // One Fibonacci step: shift left, feed the tap parity into bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/card_decode.sv
// Combinational card index (suit*13 + rank-1) to rank / suit / blackjack points.
module card_decode
   import blackjack_pkg::*;
(
   input  logic [IDX_W-1:0]  idx,
   output logic [RANK_W-1:0] rank,
   output logic [SUIT_W-1:0] suit,
   output logic [PTS_W-1:0]  points
);

   logic [IDX_W-1:0] base;

   // Suit by range compare instead of a divider; rank is the offset inside the suit.
   always_comb begin
      suit = 2'd0;
      base = 6'd0;
      if (idx >= 6'd39) begin
         suit = 2'd3;
         base = 6'd39;
      end else if (idx >= 6'd26) begin
         suit = 2'd2;
         base = 6'd26;
      end else if (idx >= 6'd13) begin
         suit = 2'd1;
         base = 6'd13;
      end
      rank   = RANK_W'(idx - base) + 4'd1;
      // Ace stays 1 here; the controller promotes it to 11 when that helps.
      points = (rank > 4'd10) ? 4'd10 : rank;
   end

endmodule

// File: rtl/deck_shuffler.sv
// 52-card deck: ordered load, LFSR-driven Fisher-Yates shuffle, then one card per draw.
module deck_shuffler
   import blackjack_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              shuffle,
   input  logic              draw,
   output logic              ready,
   output logic              empty,
   output logic              card_valid,
   output logic [RANK_W-1:0] card_rank,
   output logic [SUIT_W-1:0] card_suit,
   output logic [PTS_W-1:0]  card_points,
   output logic [IDX_W-1:0]  cards_left
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);

   deck_state_e       state_q, state_d;
   logic [IDX_W-1:0]  deck_q [DECK_SIZE];
   logic [IDX_W-1:0]  k_q, k_d;        // load counter in INIT
   logic [IDX_W-1:0]  i_q, i_d;        // Fisher-Yates upper index
   logic [IDX_W-1:0]  j_q, j_d;        // latched swap partner
   logic [IDX_W-1:0]  ptr_q, ptr_d;    // next card to deal
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic              valid_q, valid_d;
   logic [RANK_W-1:0] rank_q, rank_d;
   logic [SUIT_W-1:0] suit_q, suit_d;
   logic [PTS_W-1:0]  pts_q, pts_d;

   logic [IDX_W-1:0]  cand;
   logic [IDX_W-1:0]  top_idx;
   logic [RANK_W-1:0] dec_rank;
   logic [SUIT_W-1:0] dec_suit;
   logic [PTS_W-1:0]  dec_pts;

   // LFSR never holds 0, so the candidate spans 0..62.
   assign cand    = lfsr_q - 6'd1;
   assign top_idx = (ptr_q <= LAST_IDX) ? deck_q[ptr_q] : '0;

   card_decode u_decode (
      .idx    (top_idx),
      .rank   (dec_rank),
      .suit   (dec_suit),
      .points (dec_pts)
   );

   // State and control registers; reset restarts the load with the seed reloaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         k_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         ptr_q   <= '0;
         lfsr_q  <= SEED;
         valid_q <= 1'b0;
         rank_q  <= '0;
         suit_q  <= '0;
         pts_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         i_q     <= i_d;
         j_q     <= j_d;
         ptr_q   <= ptr_d;
         lfsr_q  <= lfsr_d;
         valid_q <= valid_d;
         rank_q  <= rank_d;
         suit_q  <= suit_d;
         pts_q   <= pts_d;
      end
   end

   // Deck storage: identity fill during INIT, in-place exchange during SWAP.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == ST_INIT) begin
            deck_q[k_q] <= k_q;
         end else if (state_q == ST_SWAP) begin
            deck_q[i_q] <= deck_q[j_q];
            deck_q[j_q] <= deck_q[i_q];
         end
      end
   end

   // Next-state and datapath control; shuffle beats draw when both arrive in READY.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      i_d     = i_q;
      j_d     = j_q;
      ptr_d   = ptr_q;
      lfsr_d  = lfsr_q;
      valid_d = 1'b0;
      rank_d  = rank_q;
      suit_d  = suit_q;
      pts_d   = pts_q;
      case (state_q)
         ST_INIT: begin
            k_d = k_q + 6'd1;
            if (k_q == LAST_IDX) begin
               k_d     = '0;
               i_d     = LAST_IDX;
               state_d = ST_PICK;
            end
         end
         ST_PICK: begin
            lfsr_d = lfsr_step(lfsr_q);
            if (cand <= i_q) begin
               j_d     = cand;
               state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            if (i_q == 6'd1) begin
               ptr_d   = '0;
               state_d = ST_READY;
            end else begin
               i_d     = i_q - 6'd1;
               state_d = ST_PICK;
            end
         end
         ST_READY: begin
            if (shuffle) begin
               ptr_d   = '0;
               k_d     = '0;
               state_d = ST_INIT;
            end else if (draw) begin
               valid_d = 1'b1;
               rank_d  = dec_rank;
               suit_d  = dec_suit;
               pts_d   = dec_pts;
               ptr_d   = ptr_q + 6'd1;
               if (ptr_q == LAST_IDX) begin
                  state_d = ST_EMPTY;
               end
            end
         end
         ST_EMPTY: begin
            if (shuffle) begin
               ptr_d   = '0;
               k_d     = '0;
               state_d = ST_INIT;
            end
         end
         default: begin
            state_d = ST_INIT;
            k_d     = '0;
            ptr_d   = '0;
         end
      endcase
   end

   assign ready       = (state_q == ST_READY);
   assign empty       = (state_q == ST_EMPTY);
   assign card_valid  = valid_q;
   assign card_rank   = rank_q;
   assign card_suit   = suit_q;
   assign card_points = pts_q;
   assign cards_left  = IDX_W'(DECK_SIZE) - ptr_q;

endmodule
